gcn_layer_sequencer: RTL

// - Top-level phase controller for one GCN layer.
// - Runs the transformation engine (FM x WM into the FM_WM product memory), then the aggregation engine.
// - Owns the single shared feature/weight memory read port and grants it to the active engine.
// - Routes aggregation's row index to the FM_WM read port. Adds a start/done handshake and a stall watchdog.

---
 rtl/gcn_pkg.sv | 38 +++
 rtl/gcn_watchdog.sv | 57 +++++
 rtl/gcn_layer_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// -----------------------------------------------------------------------------
// gcn_pkg
// Shared types and default sizes for the GCN layer sequencer.
//   seq_state_t      : layer phase FSM encoding
//   GCN_*            : default parameter values used by gcn_layer_sequencer
//   is_run_state()   : true in the two RUN phases (where the watchdog counts)
//   is_trans_phase() : true while the transformation engine owns memory
//   is_agg_phase()   : true while the aggregation engine owns memory
// -----------------------------------------------------------------------------
package gcn_pkg;

   localparam int GCN_ADDRESS_WIDTH  = 13;
   localparam int GCN_FEATURE_WIDTH  = 3;
   localparam int GCN_TIMEOUT_CYCLES = 4096;
   localparam int GCN_PERF_WIDTH     = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      T_START = 3'd1,
      T_RUN   = 3'd2,
      A_START = 3'd3,
      A_RUN   = 3'd4,
      FIN     = 3'd5
   } seq_state_t;

   function automatic logic is_run_state(input seq_state_t s);
      return (s == T_RUN) || (s == A_RUN);
   endfunction

   function automatic logic is_trans_phase(input seq_state_t s);
      return (s == T_START) || (s == T_RUN);
   endfunction

   function automatic logic is_agg_phase(input seq_state_t s);
      return (s == A_START) || (s == A_RUN);
   endfunction

endpackage

// File: rtl/gcn_watchdog.sv
// -----------------------------------------------------------------------------
// gcn_watchdog
// Stall counter for one RUN phase. The count is cleared by 'clear' and
// advances on every 'enable' cycle. 'timeout' is asserted combinationally in
// the enabled cycle whose increment brings the count to TIMEOUT_CYCLES-1, so a
// phase that never finishes is aborted after TIMEOUT_CYCLES-1 RUN cycles.
// TIMEOUT_CYCLES = 0 disables the watchdog entirely (no counter flops).
// Ports:
//   clk     in  clock, rising edge
//   reset   in  asynchronous, active-low reset
//   clear   in  restart the count from zero
//   enable  in  count this cycle
//   timeout out stall detected in this enabled cycle
// -----------------------------------------------------------------------------
module gcn_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clk, reset, clear, enable};
         assign timeout       = 1'b0;
      end else if (TIMEOUT_CYCLES == 1) begin : g_immediate
         // Limit of zero cycles: the first RUN cycle already times out.
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clk, reset, clear};
         assign timeout       = enable;
      end else begin : g_counter
         localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
         localparam logic [CW-1:0] TRIP = CW'(TIMEOUT_CYCLES - 2);

         logic [CW-1:0] count_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               count_reg <= '0;
            end else if (clear) begin
               count_reg <= '0;
            end else if (enable && (count_reg != LAST)) begin
               count_reg <= count_reg + 1'b1;
            end
         end

         // Fires when this cycle's increment would reach TIMEOUT_CYCLES-1.
         assign timeout = enable && (count_reg == TRIP);
      end
   endgenerate

endmodule

// File: rtl/gcn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// gcn_layer_sequencer
// Phase controller for one GCN layer: runs the transformation engine, then the
// aggregation engine, arbitrating the shared feature/weight memory read port
// and steering the aggregation row index to the FM_WM product memory.
// A watchdog aborts a stalled RUN phase and raises a sticky error.
//
// Optional feature macro: GCN_SEQ_PERF_EN
//   defined   : trans_cycles / agg_cycles count T_RUN / A_RUN cycles
//               (cleared on accepted start, saturating, held afterwards)
//   undefined : both outputs tied to zero, no counter flops
//
// Ports:
//   clk, reset                         clock / async active-low reset
//   start                              layer request (level, sampled in IDLE)
//   busy, done, error                  status (done is a 1-cycle pulse)
//   start_trans, done_trans            transformation handshake
//   trans_read_en, trans_read_addr     transformation read request
//   start_agg, done_agg                aggregation handshake
//   agg_read_en, agg_read_addr         aggregation read request
//   agg_row                            aggregation FM_WM row request
//   mem_read_en, mem_read_addr         granted memory read port
//   fm_wm_read_row                     row index to FM_WM memory
//   trans_cycles, agg_cycles           phase cycle counters
// -----------------------------------------------------------------------------
module gcn_layer_sequencer
   import gcn_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = GCN_ADDRESS_WIDTH,
   parameter int FEATURE_WIDTH  = GCN_FEATURE_WIDTH,
   parameter int TIMEOUT_CYCLES = GCN_TIMEOUT_CYCLES,
   parameter int PERF_WIDTH     = GCN_PERF_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic                     start_trans,
   input  logic                     done_trans,
   input  logic                     trans_read_en,
   input  logic [ADDRESS_WIDTH-1:0] trans_read_addr,
   output logic                     start_agg,
   input  logic                     done_agg,
   input  logic                     agg_read_en,
   input  logic [ADDRESS_WIDTH-1:0] agg_read_addr,
   input  logic [FEATURE_WIDTH-1:0] agg_row,
   output logic                     mem_read_en,
   output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
   output logic [FEATURE_WIDTH-1:0] fm_wm_read_row,
   output logic [PERF_WIDTH-1:0]    trans_cycles,
   output logic [PERF_WIDTH-1:0]    agg_cycles
);

   seq_state_t state_reg;
   seq_state_t state_next;
   logic       error_reg;
   logic       error_next;
   logic       timeout;
   logic       start_accept;

   assign start_accept = (state_reg == IDLE) && start;

   // ---------------------------------------------------------------- watchdog
   // Cleared in the START cycle so the count begins at zero on RUN entry.
   gcn_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   ((state_reg == T_START) || (state_reg == A_START)),
      .enable  (is_run_state(state_reg)),
      .timeout (timeout)
   );

   // ------------------------------------------------------- state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         error_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         error_reg <= error_next;
      end
   end

   // ------------------------------------------------------- next-state logic
   // A completing engine takes priority over a same-cycle timeout.
   always_comb begin
      state_next = state_reg;
      error_next = error_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = T_START;
               error_next = 1'b0;
            end
         end
         T_START: state_next = T_RUN;
         T_RUN: begin
            if (done_trans) begin
               state_next = A_START;
            end else if (timeout) begin
               state_next = IDLE;
               error_next = 1'b1;
            end
         end
         A_START: state_next = A_RUN;
         A_RUN: begin
            if (done_agg) begin
               state_next = FIN;
            end else if (timeout) begin
               state_next = IDLE;
               error_next = 1'b1;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------- output logic
   // Grant is decoded from the registered state only, so the memory port
   // follows the phase with no added latency; the loser's request is dropped.
   always_comb begin
      busy           = 1'b0;
      done           = 1'b0;
      start_trans    = 1'b0;
      start_agg      = 1'b0;
      mem_read_en    = 1'b0;
      mem_read_addr  = '0;
      fm_wm_read_row = '0;
      case (state_reg)
         T_START: begin
            busy          = 1'b1;
            start_trans   = 1'b1;
            mem_read_en   = trans_read_en;
            mem_read_addr = trans_read_addr;
         end
         T_RUN: begin
            busy          = 1'b1;
            mem_read_en   = trans_read_en;
            mem_read_addr = trans_read_addr;
         end
         A_START: begin
            busy           = 1'b1;
            start_agg      = 1'b1;
            mem_read_en    = agg_read_en;
            mem_read_addr  = agg_read_addr;
            fm_wm_read_row = agg_row;
         end
         A_RUN: begin
            busy           = 1'b1;
            mem_read_en    = agg_read_en;
            mem_read_addr  = agg_read_addr;
            fm_wm_read_row = agg_row;
         end
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign error = error_reg;

   // ------------------------------------------------------- perf counters
`ifdef GCN_SEQ_PERF_EN
   logic [PERF_WIDTH-1:0] trans_cycles_reg;
   logic [PERF_WIDTH-1:0] agg_cycles_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trans_cycles_reg <= '0;
         agg_cycles_reg   <= '0;
      end else if (start_accept) begin
         trans_cycles_reg <= '0;
         agg_cycles_reg   <= '0;
      end else begin
         if ((state_reg == T_RUN) && (trans_cycles_reg != '1)) begin
            trans_cycles_reg <= trans_cycles_reg + 1'b1;
         end
         if ((state_reg == A_RUN) && (agg_cycles_reg != '1)) begin
            agg_cycles_reg <= agg_cycles_reg + 1'b1;
         end
      end
   end

   assign trans_cycles = trans_cycles_reg;
   assign agg_cycles   = agg_cycles_reg;
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
   assign trans_cycles        = '0;
   assign agg_cycles          = '0;
`endif

endmodule
